// File: rtl/alu_operand_stage.sv
// Decode-to-execute operand stage: builds the RV32I immediate, selects ALU operand B
// and holds up to two entries in a skid buffer with registered in_ready/out_valid.
module alu_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_imm_type,
    input  logic            in_alusrc,
    input  logic [XLEN-1:0] in_rd1,
    input  logic [XLEN-1:0] in_rd2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op_a,
    output logic [XLEN-1:0] out_op_b,
    output logic [XLEN-1:0] out_rs2,
    output logic [XLEN-1:0] out_imm
);

    localparam logic ALU_RD2    = 1'b0;
    localparam logic ALU_EXTEND = 1'b1;
    localparam int   EW         = 4 * XLEN;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic logic [31:0] extend_imm(input logic [31:0] i, input logic [2:0] t);
        logic [31:0] v;
        case (t)
            3'd0:    v = {{20{i[31]}}, i[31:20]};
            3'd1:    v = {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    v = {i[31:12], 12'd0};
            3'd4:    v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [EW-1:0]   r_head;
    logic [EW-1:0]   r_tail;
    logic [EW-1:0]   w_entry;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_op_b;
    logic            w_accept;
    logic            w_release;
    logic            w_load_head;
    logic            w_load_tail;
    logic            w_head_from_tail;

    assign w_imm     = extend_imm(in_instr, in_imm_type);
    assign w_accept  = in_valid & r_in_ready;
    assign w_release = r_out_valid & out_ready;
    assign w_entry   = {in_rd1, w_op_b, in_rd2, w_imm};

    // Operand B source mux driven by the decoder's ALU source encoding.
    always_comb begin
        w_op_b = in_rd2;
        case (in_alusrc)
            ALU_RD2:    w_op_b = in_rd2;
            ALU_EXTEND: w_op_b = w_imm;
            default:    w_op_b = in_rd2;
        endcase
    end

    // Buffer next-state and entry load steering; flush overrides every handshake.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_head      = 1'b0;
        w_load_tail      = 1'b0;
        w_head_from_tail = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_load_head = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_release) begin
                        w_state_nxt = ST_ONE;
                        w_load_head = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_load_tail = 1'b1;
                    end else if (w_release) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (w_release) begin
                        w_state_nxt      = ST_ONE;
                        w_head_from_tail = 1'b1;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // State register with handshake flags decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // Entry storage: head always holds the oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= {EW{1'b0}};
            r_tail <= {EW{1'b0}};
        end else begin
            if (w_load_head) begin
                r_head <= w_entry;
            end else if (w_head_from_tail) begin
                r_head <= r_tail;
            end else begin
                r_head <= r_head;
            end
            if (w_load_tail) begin
                r_tail <= w_entry;
            end else begin
                r_tail <= r_tail;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_op_a  = r_head[4*XLEN-1:3*XLEN];
    assign out_op_b  = r_head[3*XLEN-1:2*XLEN];
    assign out_rs2   = r_head[2*XLEN-1:XLEN];
    assign out_imm   = r_head[XLEN-1:0];

endmodule
